mem_align_seq: RTL and testbench
================================

MEM_ALIGN_SEQ -- requirements
Module: mem_align_seq

Interface
REQ-001 SHALL provide parameter ADDRESS_WIDTH, default 32, byte-address width.
REQ-002 SHALL provide parameter DATA_WIDTH, default 32, data width; only 32 is supported.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port req_valid, input, 1 bit: an EX/MEM load or store request is present.
REQ-006 SHALL have port req_we, input, 1 bit: 1 = store, 0 = load.
REQ-007 SHALL have port req_funct3, input, 3 bits: RISC-V load/store funct3.
REQ-008 SHALL have port req_addr, input, ADDRESS_WIDTH bits: byte address.
REQ-009 SHALL have port req_wdata, input, DATA_WIDTH bits: store data.
REQ-010 SHALL have port flush, input, 1 bit: abort any in-progress sequence.
REQ-011 SHALL have port mem_write_e, output, 1 bit: write strobe to data memory.
REQ-012 SHALL have port mem_funct3, output, 3 bits: access size sent to data memory.
REQ-013 SHALL have port mem_addr, output, ADDRESS_WIDTH bits: address sent to data memory.
REQ-014 SHALL have port mem_wdata, output, DATA_WIDTH bits: write data sent to data memory.
REQ-015 SHALL have port mem_rdata, input, DATA_WIDTH bits: asynchronous read data from data memory.
REQ-016 SHALL have port load_data, output, DATA_WIDTH bits: final extended load result.
REQ-017 SHALL have port load_valid, output, 1 bit: load_data is valid this cycle.
REQ-018 SHALL have port stall, output, 1 bit: holds the pipeline; the upstream stage keeps all req_* inputs stable while stall=1.

Function
REQ-019 Misalignment SHALL be defined as: halfword with addr[0]=1; word with addr[1:0]!=0. Byte accesses are never misaligned.
REQ-020 Aligned requests SHALL pass through combinationally: req_* drive mem_*, load_data = mem_rdata, load_valid = req_valid & ~req_we, stall=0, with no state change.
REQ-021 The FSM SHALL have states IDLE, LD_HI and ST_BYTE; reset state is IDLE.
REQ-022 A misaligned load in IDLE SHALL take two cycles:
  - Cycle T: mem_addr = addr & ~3, mem_funct3 = 010, stall = 1; mem_rdata is captured into lo_q; the FSM moves to LD_HI.
  - Cycle T+1 (LD_HI): mem_addr = (addr & ~3) + 4, mem_funct3 = 010, stall = 0, load_valid = 1; the FSM returns to IDLE.
REQ-023 The load result SHALL be {mem_rdata, lo_q} shifted right by 8*addr[1:0], truncated to 16 or 32 bits, and sign- or zero-extended per funct3 (lh/lhu/lw).
REQ-024 A misaligned store SHALL be split into N byte stores (N = 2 for sh, 4 for sw), one per cycle:
  - Byte i is written at addr+i with mem_funct3 = 000.
  - req_wdata[8i+7:8i] is replicated into all four lanes of mem_wdata.
  - mem_write_e = 1 on every byte cycle.
  - stall = 1 on the first N-1 cycles and 0 on the last.
  - The byte counter is held in ST_BYTE.
REQ-025 After the last byte store, the FSM SHALL return to IDLE.
REQ-026 Address arithmetic SHALL wrap modulo 2^ADDRESS_WIDTH.
REQ-027 With flush=1, the block SHALL return to IDLE next cycle and drive load_valid=0, stall=0 and mem_write_e=0 that cycle. Byte stores already issued remain in memory.
REQ-028 With req_valid=0 in IDLE, the block SHALL drive mem_write_e=0, load_valid=0 and stall=0.
REQ-029 An unsupported funct3 SHALL be treated as aligned passthrough with mem_write_e forced to 0.

Reset
REQ-030 While rst=1, the block SHALL force mem_write_e=0, load_valid=0, stall=0, state=IDLE, lo_q=0 and byte counter=0.
REQ-031 rst SHALL take priority over flush and over requests.
REQ-032 Reset mid-sequence SHALL abandon the sequence; bytes already written SHALL NOT be undone.

Structure
REQ-033 The FSM state encodings and funct3 constants (LB, LH, LW, LBU, LHU, SB, SH, SW) SHALL live in the shared package rv_mem_pkg.
REQ-034 The shift, truncate and extend logic SHALL be a sub-module named load_extend.

Verification
Initial memory for all scenarios: word0 = 0x44332211, word1 = 0x887766A5.
REQ-035 lw 0x0 -> same cycle: load_data = 0x44332211, load_valid = 1, stall = 0.
REQ-036 lw 0x1 -> T: stall = 1, mem_addr = 0x0; T+1: mem_addr = 0x4, stall = 0, load_data = 0xA5443322.
REQ-037 lh 0x3 -> T+1: load_data = 0xFFFFA544; lhu 0x3 -> T+1: load_data = 0x0000A544.
REQ-038 sw 0xDEADBEEF at 0x2 -> byte stores EF@0x2, BE@0x3, AD@0x4, DE@0x5 with stall = 1,1,1,0; afterwards word0 = 0xBEEF2211, word1 = 0x8877DEAD.
REQ-039 Same sw with rst asserted in its 2nd cycle -> only 0x2 written (word0 = 0x44EF2211); next cycle stall = 0, mem_write_e = 0, FSM in IDLE.
REQ-040 lw 0x1 with flush asserted in LD_HI -> load_valid = 0 that cycle; the following aligned lw 0x0 returns 0x44332211.

Source files
------------

// File: rtl/rv_mem_pkg.sv
// rtl/rv_mem_pkg.sv - shared load/store constants and helpers for the alignment sequencer
package rv_mem_pkg;

  // FSM state encodings
  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] LD_HI   = 2'd1;
  localparam logic [1:0] ST_BYTE = 2'd2;

  // RISC-V load funct3 codes
  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;

  // RISC-V store funct3 codes
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

  // True when funct3 names a real load (we=0) or store (we=1)
  function automatic logic f3_supported(input logic we, input logic [2:0] f3);
    if (we) begin
      return (f3 == SB) || (f3 == SH) || (f3 == SW);
    end
    return (f3 == LB) || (f3 == LH) || (f3 == LW) || (f3 == LBU) || (f3 == LHU);
  endfunction

  // Halfwords need addr[0]=0, words need addr[1:0]=0; bytes always fit
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] addr_lo);
    case (f3[1:0])
      2'b01:   return addr_lo[0];
      2'b10:   return addr_lo != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/load_extend.sv
// rtl/load_extend.sv - shift, truncate and extend a load spanning two memory words
module load_extend
  import rv_mem_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  input  logic [31:0] lo_word,
  input  logic [31:0] hi_word,
  output logic [31:0] data
);

  logic [31:0] window;

  // The two words form a 64-bit little-endian window; the wanted bytes start at offset
  assign window = 32'({hi_word, lo_word} >> {offset, 3'b000});

  // Keep the access size and apply sign or zero extension
  always_comb begin
    data = window;
    case (funct3)
      LB:      data = {{24{window[7]}}, window[7:0]};
      LBU:     data = {24'd0, window[7:0]};
      LH:      data = {{16{window[15]}}, window[15:0]};
      LHU:     data = {16'd0, window[15:0]};
      default: data = window;
    endcase
  end

endmodule

// File: rtl/mem_align_seq.sv
// rtl/mem_align_seq.sv - splits misaligned RISC-V loads/stores into aligned memory accesses
module mem_align_seq
  import rv_mem_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  input  logic                     req_we,
  input  logic [2:0]               req_funct3,
  input  logic [ADDRESS_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0]    req_wdata,
  input  logic                     flush,
  output logic                     mem_write_e,
  output logic [2:0]               mem_funct3,
  output logic [ADDRESS_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]    mem_wdata,
  input  logic [DATA_WIDTH-1:0]    mem_rdata,
  output logic [DATA_WIDTH-1:0]    load_data,
  output logic                     load_valid,
  output logic                     stall
);

  logic [1:0]               state_q, state_d;
  logic [1:0]               cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]    lo_q, lo_d;
  logic [ADDRESS_WIDTH-1:0] word_base;
  logic [1:0]               byte_sel;
  logic [1:0]               last_idx;
  logic                     last_byte;
  logic [7:0]               st_byte;
  logic [DATA_WIDTH-1:0]    ext_data;

  assign word_base = req_addr & ~ADDRESS_WIDTH'(3);
  // In IDLE the counter is always zero, but select explicitly so the first byte never depends on it
  assign byte_sel  = (state_q == ST_BYTE) ? cnt_q : 2'd0;
  assign st_byte   = req_wdata[{byte_sel, 3'b000} +: 8];
  assign last_idx  = (req_funct3 == SH) ? 2'd1 : 2'd3;
  assign last_byte = (cnt_q == last_idx);

  // The upper word arrives live in LD_HI; the lower word was captured the cycle before
  load_extend u_load_extend (
    .funct3  (req_funct3),
    .offset  (req_addr[1:0]),
    .lo_word (lo_q),
    .hi_word (mem_rdata),
    .data    (ext_data)
  );

  // Output steering and next-state selection; reset and flush squash all side effects
  always_comb begin
    mem_write_e = 1'b0;
    mem_funct3  = req_funct3;
    mem_addr    = req_addr;
    mem_wdata   = req_wdata;
    load_data   = mem_rdata;
    load_valid  = 1'b0;
    stall       = 1'b0;
    state_d     = state_q;
    cnt_d       = cnt_q;
    lo_d        = lo_q;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (!f3_supported(req_we, req_funct3)) begin
            load_valid = ~req_we;
          end else if (!is_misaligned(req_funct3, req_addr[1:0])) begin
            mem_write_e = req_we;
            load_valid  = ~req_we;
          end else if (!req_we) begin
            mem_addr   = word_base;
            mem_funct3 = LW;
            stall      = 1'b1;
            lo_d       = mem_rdata;
            state_d    = LD_HI;
          end else begin
            mem_funct3  = SB;
            mem_wdata   = {4{st_byte}};
            mem_write_e = 1'b1;
            stall       = 1'b1;
            cnt_d       = 2'd1;
            state_d     = ST_BYTE;
          end
        end
      end
      LD_HI: begin
        mem_addr   = word_base + ADDRESS_WIDTH'(4);
        mem_funct3 = LW;
        load_data  = ext_data;
        load_valid = 1'b1;
        state_d    = IDLE;
      end
      ST_BYTE: begin
        mem_addr    = req_addr + ADDRESS_WIDTH'(cnt_q);
        mem_funct3  = SB;
        mem_wdata   = {4{st_byte}};
        mem_write_e = 1'b1;
        stall       = ~last_byte;
        cnt_d       = last_byte ? 2'd0 : cnt_q + 2'd1;
        state_d     = last_byte ? IDLE : ST_BYTE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 2'd0;
      end
    endcase

    if (rst || flush) begin
      mem_write_e = 1'b0;
      load_valid  = 1'b0;
      stall       = 1'b0;
      state_d     = IDLE;
      cnt_d       = 2'd0;
      lo_d        = lo_q;
    end
  end

  // Sequencer state; reset wins over everything
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 2'd0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lo_q    <= lo_d;
    end
  end

endmodule

// File: tb/tb_mem_align_seq.sv
// tb/tb_mem_align_seq.sv - self-checking bench for mem_align_seq with byte-level memory model
module tb_mem_align_seq;
  import rv_mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        flush;
  logic        mem_write_e;
  logic [2:0]  mem_funct3;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic [31:0] load_data;
  logic        load_valid;
  logic        stall;

  logic [7:0]  mem     [0:63];
  logic [7:0]  ref_mem [0:63];
  logic        init_req;
  logic [5:0]  rd_wa;
  logic [31:0] rd_word;
  logic [31:0] rd_sh;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_align_seq #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_we      (req_we),
    .req_funct3  (req_funct3),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .flush       (flush),
    .mem_write_e (mem_write_e),
    .mem_funct3  (mem_funct3),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .load_data   (load_data),
    .load_valid  (load_valid),
    .stall       (stall)
  );

  function automatic logic [7:0] init_byte(input int i);
    case (i)
      0: return 8'h11;  1: return 8'h22;  2: return 8'h33;  3: return 8'h44;
      4: return 8'hA5;  5: return 8'h66;  6: return 8'h77;  7: return 8'h88;
      default: return 8'(i * 37 + 11);
    endcase
  endfunction

  // 64-byte data memory, address taken modulo 64; sized reads like a real RV data port
  always_comb begin
    rd_wa   = {mem_addr[5:2], 2'b00};
    rd_word = {mem[rd_wa + 6'd3], mem[rd_wa + 6'd2], mem[rd_wa + 6'd1], mem[rd_wa]};
    rd_sh   = rd_word >> {mem_addr[1:0], 3'b000};
    case (mem_funct3)
      LB:      mem_rdata = {{24{rd_sh[7]}}, rd_sh[7:0]};
      LBU:     mem_rdata = {24'd0, rd_sh[7:0]};
      LH:      mem_rdata = {{16{rd_sh[15]}}, rd_sh[15:0]};
      LHU:     mem_rdata = {16'd0, rd_sh[15:0]};
      default: mem_rdata = rd_word;
    endcase
  end

  // Memory writes take the low bytes of wdata
  always @(posedge clk) begin
    if (init_req) begin
      for (int i = 0; i < 64; i++) mem[i] <= init_byte(i);
    end else if (mem_write_e) begin
      case (mem_funct3)
        SB: mem[mem_addr[5:0]] <= mem_wdata[7:0];
        SH: begin
          mem[mem_addr[5:0]]         <= mem_wdata[7:0];
          mem[mem_addr[5:0] + 6'd1]  <= mem_wdata[15:8];
        end
        default: begin
          mem[{mem_addr[5:2], 2'b00}]         <= mem_wdata[7:0];
          mem[{mem_addr[5:2], 2'b00} + 6'd1]  <= mem_wdata[15:8];
          mem[{mem_addr[5:2], 2'b00} + 6'd2]  <= mem_wdata[23:16];
          mem[{mem_addr[5:2], 2'b00} + 6'd3]  <= mem_wdata[31:24];
        end
      endcase
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  task automatic init_mem();
    init_req = 1'b1;
    for (int i = 0; i < 64; i++) ref_mem[i] = init_byte(i);
    @(posedge clk); #1;
    init_req = 1'b0;
  endtask

  function automatic logic [31:0] mem_word(input int w);
    return {mem[4*w+3], mem[4*w+2], mem[4*w+1], mem[4*w]};
  endfunction

  function automatic logic [31:0] ref_word(input int w);
    return {ref_mem[4*w+3], ref_mem[4*w+2], ref_mem[4*w+1], ref_mem[4*w]};
  endfunction

  // Reference load: gather bytes little-endian, then extend by size/signedness
  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a);
    logic [31:0] v;
    int sz;
    v  = '0;
    sz = 1 << f3[1:0];
    for (int i = 0; i < sz; i++) v[8*i +: 8] = ref_mem[6'(a + 32'(i))];
    if (!f3[2] && sz == 1) v = {{24{v[7]}}, v[7:0]};
    if (!f3[2] && sz == 2) v = {{16{v[15]}}, v[15:0]};
    return v;
  endfunction

  // Hold a request until stall drops; report cycles used and load results
  task automatic run_op(input logic we, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, output int cyc, output int lv_cnt,
                        output logic [31:0] ld);
    logic st;
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
    cyc = 0; lv_cnt = 0; ld = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (load_valid) begin
        lv_cnt++;
        ld = load_data;
      end
      st = stall;
      @(posedge clk); #1;
      if (!st || cyc >= 8) break;
    end
    req_valid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int cyc, lv_cnt, sz, r;
    logic [31:0] ld, exp_ld, a, wd;
    logic [2:0]  f3;
    logic        we, mis;

    rst = 1'b1; flush = 1'b0; init_req = 1'b0;
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = SW; req_addr = 32'h1; req_wdata = 32'h12345678;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_stall", {31'd0, stall}, 32'd0);
    check("rst_we", {31'd0, mem_write_e}, 32'd0);
    req_we = 1'b0; req_funct3 = LW;
    @(negedge clk);
    check("rst_lv", {31'd0, load_valid}, 32'd0);
    check("rst_ld_stall", {31'd0, stall}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; req_valid = 1'b0;
    init_mem();

    @(negedge clk);
    check("idle_outs", {29'd0, stall, load_valid, mem_write_e}, 32'd0);
    @(posedge clk); #1;

    // aligned lw 0x0
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = LW; req_addr = 32'h0;
    @(negedge clk);
    check("lw0_data", load_data, 32'h44332211);
    check("lw0_lv_stall", {30'd0, load_valid, stall}, 32'd2);
    @(posedge clk); #1;

    // misaligned lw 0x1
    req_addr = 32'h1;
    @(negedge clk);
    check("lw1_T_stall", {31'd0, stall}, 32'd1);
    check("lw1_T_addr", mem_addr, 32'h0);
    @(posedge clk); #1;
    @(negedge clk);
    check("lw1_T1_addr", mem_addr, 32'h4);
    check("lw1_T1_lv_stall", {30'd0, load_valid, stall}, 32'd2);
    check("lw1_T1_data", load_data, 32'hA5443322);
    @(posedge clk); #1;
    req_valid = 1'b0;

    run_op(1'b0, LH, 32'h3, 32'h0, cyc, lv_cnt, ld);
    check("lh3_data", ld, 32'hFFFFA544);
    check("lh3_cyc", 32'(cyc), 32'd2);
    run_op(1'b0, LHU, 32'h3, 32'h0, cyc, lv_cnt, ld);
    check("lhu3_data", ld, 32'h0000A544);

    // sw 0xDEADBEEF @ 0x2 cycle by cycle
    wd = 32'hDEADBEEF;
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = SW; req_addr = 32'h2; req_wdata = wd;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("sw_we", {31'd0, mem_write_e}, 32'd1);
      check("sw_addr", mem_addr, 32'h2 + 32'(i));
      check("sw_wdata", mem_wdata, {4{wd[8*i +: 8]}});
      check("sw_stall", {31'd0, stall}, (i < 3) ? 32'd1 : 32'd0);
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    check("sw_word0", mem_word(0), 32'hBEEF2211);
    check("sw_word1", mem_word(1), 32'h8877DEAD);

    // same sw, reset in its second cycle
    init_mem();
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = SW; req_addr = 32'h2; req_wdata = wd;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("swrst_we", {31'd0, mem_write_e}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; req_valid = 1'b0;
    @(negedge clk);
    check("swrst_after", {30'd0, stall, mem_write_e}, 32'd0);
    @(posedge clk); #1;
    check("swrst_word0", mem_word(0), 32'h44EF2211);
    check("swrst_word1", mem_word(1), 32'h887766A5);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = LW; req_addr = 32'h0;
    @(negedge clk);
    check("swrst_lw0", load_data, 32'h44EF2211);
    check("swrst_lw0_stall", {30'd0, load_valid, stall}, 32'd2);
    @(posedge clk); #1;
    req_valid = 1'b0;

    // lw 0x1 flushed in LD_HI
    init_mem();
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = LW; req_addr = 32'h1;
    @(negedge clk);
    @(posedge clk); #1;
    flush = 1'b1;
    @(negedge clk);
    check("flush_lv_stall", {30'd0, load_valid, stall}, 32'd0);
    @(posedge clk); #1;
    flush = 1'b0; req_addr = 32'h0;
    @(negedge clk);
    check("flush_lw0", load_data, 32'h44332211);
    check("flush_lw0_stall", {30'd0, load_valid, stall}, 32'd2);
    @(posedge clk); #1;
    req_valid = 1'b0;

    // address wrap
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = LW; req_addr = 32'hFFFFFFFF;
    @(negedge clk);
    check("wrap_lo_addr", mem_addr, 32'hFFFFFFFC);
    @(posedge clk); #1;
    @(negedge clk);
    check("wrap_hi_addr", mem_addr, 32'h0);
    check("wrap_data", load_data, model_load(LW, 32'hFFFFFFFF));
    @(posedge clk); #1;
    req_we = 1'b1; req_funct3 = SH; req_wdata = 32'h0000C3D4;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    check("wrap_sh_addr", mem_addr, 32'h0);
    check("wrap_sh_wdata", mem_wdata, 32'hC3C3C3C3);
    @(posedge clk); #1;
    req_valid = 1'b0;

    // unsupported store funct3
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b011; req_addr = 32'h1;
    @(negedge clk);
    check("unsup_st", {29'd0, mem_write_e, stall, load_valid}, 32'd0);
    @(posedge clk); #1;
    req_valid = 1'b0;

    // randomized mix against the byte-level model
    init_mem();
    for (int n = 0; n < 200; n++) begin
      we = 1'($urandom_range(0, 1));
      r  = int'($urandom_range(0, 4));
      if (we) f3 = 3'($urandom_range(0, 2));
      else    f3 = (r < 3) ? 3'(r) : 3'(r + 1);
      a  = 32'($urandom_range(0, 63));
      wd = $urandom;
      sz = 1 << f3[1:0];
      mis = (sz == 2 && a[0]) || (sz == 4 && a[1:0] != 2'b00);
      exp_ld = model_load(f3, a);
      run_op(we, f3, a, wd, cyc, lv_cnt, ld);
      if (we) begin
        check("rnd_st_cyc", 32'(cyc), mis ? 32'(sz) : 32'd1);
        check("rnd_st_lv", 32'(lv_cnt), 32'd0);
        for (int i = 0; i < sz; i++) ref_mem[6'(a + 32'(i))] = wd[8*i +: 8];
        check("rnd_st_w0", mem_word(a[5:2]), ref_word(a[5:2]));
        check("rnd_st_w1", mem_word((a[5:2] + 1) % 16), ref_word((a[5:2] + 1) % 16));
      end else begin
        check("rnd_ld_cyc", 32'(cyc), mis ? 32'd2 : 32'd1);
        check("rnd_ld_lv", 32'(lv_cnt), 32'd1);
        check("rnd_ld_data", ld, exp_ld);
      end
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
